dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared 32-bit data memory `dmem`. It accepts load/store requests from two masters: port 0, the CPU data path, and port 1, the loader/DMA. It grants them round-robin and drives the single memory port with a fixed three-state access sequence. It sits between the requesters and `dmem`, and it is the only block that asserts `dmem` read/write enables.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arbiter_rr_pick2.sv | 19 +
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem two-port arbiter.
// The optional alignment check is enabled by defining DMEM_ARB_ERR_EN.
package dmem_arb_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } arb_req_t;

    // Word accesses only: any nonzero byte offset is misaligned.
    function automatic logic misaligned(input logic [DATA_W-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-request round-robin picker: rr names the winner on a tie.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       win_c,
    output logic       valid_c
);

    always_comb begin
        valid_c = |req;
        win_c   = 1'b0;
        if (req == 2'b11) begin
            win_c = rr;
        end else begin
            win_c = req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and IDLE/ACCESS/DONE sequencer for dmem.
// Define DMEM_ARB_ERR_EN to reject misaligned requests with an err pulse.
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              busy,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    arb_state_t state_q, state_d;
    arb_req_t   lat_q, lat_d;
    logic       win_q, win_d;
    logic       rr_q, rr_d;
    logic       mis_q, mis_d;
    logic       busy_q, busy_d;
    logic       mem_re_q, mem_re_d;
    logic       mem_we_q, mem_we_d;
    logic [NUM_PORTS-1:0]             done_q, done_d;
    logic [NUM_PORTS-1:0]             err_q, err_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;

    arb_req_t req_sel_c;
    logic     win_c;
    logic     grant_c;
    logic     mis_c;

    rr_pick2 u_pick (
        .req     ({req1, req0}),
        .rr      (rr_q),
        .win_c   (win_c),
        .valid_c (grant_c)
    );

    // Winner's request payload and its alignment status.
    always_comb begin
        req_sel_c.we    = win_c ? we1    : we0;
        req_sel_c.addr  = win_c ? addr1  : addr0;
        req_sel_c.wdata = win_c ? wdata1 : wdata0;
`ifdef DMEM_ARB_ERR_EN
        mis_c = misaligned(req_sel_c.addr);
`else
        mis_c = 1'b0;
`endif
    end

    // Next state and next register values; the latch doubles as the memory drive
    // and is zero outside ACCESS.
    always_comb begin
        state_d  = state_q;
        lat_d    = '0;
        win_d    = win_q;
        rr_d     = rr_q;
        mis_d    = mis_q;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        done_d   = '0;
        err_d    = '0;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d  = ACCESS;
                    lat_d    = req_sel_c;
                    win_d    = win_c;
                    rr_d     = ~win_c;
                    mis_d    = mis_c;
                    mem_we_d = req_sel_c.we & ~mis_c;
                    mem_re_d = ~req_sel_c.we & ~mis_c;
                end
            end
            ACCESS: begin
                state_d        = DONE;
                done_d[win_q]  = 1'b1;
                err_d[win_q]   = mis_q;
                if (!lat_q.we && !mis_q) begin
                    rdata_d[win_q] = mem_readdata;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            win_q    <= 1'b0;
            rr_q     <= 1'b0;
            mis_q    <= 1'b0;
            busy_q   <= 1'b0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            win_q    <= win_d;
            rr_q     <= rr_d;
            mis_q    <= mis_d;
            busy_q   <= busy_d;
            mem_re_q <= mem_re_d;
            mem_we_q <= mem_we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign done0            = done_q[0];
    assign done1            = done_q[1];
    assign err0             = err_q[0];
    assign err1             = err_q[1];
    assign rdata0           = rdata_q[0];
    assign rdata1           = rdata_q[1];
    assign busy             = busy_q;
    assign mem_read_enable  = mem_re_q;
    assign mem_write_enable = mem_we_q;
    assign mem_addr         = lat_q.addr;
    assign mem_writedata    = lat_q.wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural dmem behind it.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        done0, done1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic        mem_read_enable, mem_write_enable;
    logic [31:0] mem_addr, mem_writedata, mem_readdata;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tmem    [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rdata [0:1];
    int          tb_rr;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          we_cycles = 0;
    int          re_cycles = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req0             (req0),
        .we0              (we0),
        .addr0            (addr0),
        .wdata0           (wdata0),
        .req1             (req1),
        .we1              (we1),
        .addr1            (addr1),
        .wdata1           (wdata1),
        .done0            (done0),
        .done1            (done1),
        .rdata0           (rdata0),
        .rdata1           (rdata1),
        .err0             (err0),
        .err1             (err1),
        .busy             (busy),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory model: combinational read, write at the clock edge.
    assign mem_readdata = tmem[mem_addr[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) tmem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (mem_write_enable) tmem[mem_addr[9:2]] = mem_writedata;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Completion monitor: pops the scoreboard on every done pulse.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mem_write_enable) we_cycles++;
            if (mem_read_enable) re_cycles++;
            if (mem_write_enable || mem_read_enable)
                check("en_excl", 32'(mem_write_enable & mem_read_enable), 0);
            if (!busy || done0 || done1) begin
                check("quiet_mem_addr", mem_addr, 0);
                check("quiet_mem_wdata", mem_writedata, 0);
            end
            if (done0 || done1) begin
                exp_t e;
                done_cnt++;
                check("done_excl", 32'(done0 & done1), 0);
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_port", done1 ? 1 : 0, e.port);
                    check("rdata", done1 ? rdata1 : rdata0, e.rdata);
                    check("err", 32'(done1 ? err1 : err0), 32'(e.err));
                end
            end
        end
    end

    // Reference model: memory contents, held rdata, round-robin pointer.
    task automatic predict(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        logic mis;
        exp_t e;
`ifdef DMEM_ARB_ERR_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (!mis) begin
            if (we) ref_mem[a[9:2]] = d;
            else    exp_rdata[p]    = ref_mem[a[9:2]];
        end
        e.port  = p;
        e.rdata = exp_rdata[p];
        e.err   = mis;
        sb.push_back(e);
        tb_rr = 1 - p;
    endtask

    task automatic drive(input int p, input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // Single access on an idle arbiter; checks 2-cycle latency.
    task automatic do_single(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int  c0;
        bit  got;
        @(posedge clk); #1;
        drive(p, 1'b1, we, a, d);
        predict(p, we, a, d);
        c0  = cyc;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((p == 0) ? done0 : done1) got = 1;
        end
        check("latency", got ? 32'(cyc - c0) : 32'hFFFF_FFFF, 2);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Wait for n completions with both requests held; checks 3-cycle spacing.
    task automatic wait_completions(input int n);
        int seen = 0;
        int last = 0;
        for (int k = 0; k < n * 3 + 20 && seen < n; k++) begin
            @(negedge clk);
            if (done0 || done1) begin
                if (seen > 0) check("done_gap", 32'(cyc - last), 3);
                last = cyc;
                seen++;
            end
        end
        if (seen < n) check("wait_timeout", 32'(seen), 32'(n));
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic run_both(input int n, input logic [31:0] a0, input logic [31:0] a1);
        for (int k = 0; k < n; k++) predict(tb_rr, 1'b0, (tb_rr == 0) ? a0 : a1, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, a0, 32'h0);
        drive(1, 1'b1, 1'b0, a1, 32'h0);
        wait_completions(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, d0;
        bit hit;
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        tb_rr = 0;

        // Reset with both requests pending, then first grant to port 0.
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({done0, done1, err0, err1, busy, mem_read_enable, mem_write_enable}), 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_writedata, 0);
        predict(0, 1'b0, 32'h0, 32'h0);
        predict(1, 1'b0, 32'h4, 32'h0);
        rst_n = 1'b1;
        wait_completions(2);

        // Store from port 0, read back through port 1.
        w0 = we_cycles; r0 = re_cycles;
        do_single(0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        check("st_we_cycles", 32'(we_cycles - w0), 1);
        check("st_re_cycles", 32'(re_cycles - r0), 0);
        do_single(1, 1'b0, 32'h40, 32'h0);
        check("ld_rdata1", rdata1, 32'hDEAD_BEEF);

        // Continuous loads from both ports alternate.
        run_both(4, 32'h10, 32'h14);

        // Lone port 1, then a tie goes to port 0.
        do_single(1, 1'b0, 32'h80, 32'h0);
        run_both(2, 32'h84, 32'h88);

        // Reset during a store's ACCESS cycle.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
        hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (mem_write_enable) hit = 1;
        end
        check("mid_we_seen", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        check("mid_we_drop", 32'(mem_write_enable), 0);
        check("mid_busy_drop", 32'(busy), 0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        tb_rr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        check("mid_no_done", 32'(done_cnt - d0), 0);
        check("mid_idle", 32'(busy), 0);
        check("mid_rdata0", rdata0, 0);
        run_both(2, 32'h20, 32'h24);
        do_single(1, 1'b0, 32'h100, 32'h0);

        // Misaligned store.
        w0 = we_cycles; r0 = re_cycles;
        do_single(0, 1'b1, 32'h42, 32'hBADC_0FFE);
`ifdef DMEM_ARB_ERR_EN
        check("mis_we_cycles", 32'(we_cycles - w0), 0);
`else
        check("mis_we_cycles", 32'(we_cycles - w0), 1);
`endif
        check("mis_re_cycles", 32'(re_cycles - r0), 0);
        do_single(1, 1'b0, 32'h40, 32'h0);

        // Random single accesses.
        for (int k = 0; k < 10; k++) begin
            int          p;
            logic        we;
            logic [31:0] a;
            p  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = 32'h200 + (32'($urandom_range(0, 15)) << 2);
            do_single(p, we, a, $urandom);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
